attack_sequencer: RTL

- Mode sequencer for the tank drive/turret mux.
- Generates the `pr`, `turn_start` and `fire` controls that select between the find datapath and the pursue/border/turn datapath, and that trigger the turret.
- Sits between the sensor-conditioning blocks (target lock, border detect, overcurrent) and the drive mux.
- Replaces the free-running switch-driven mode bits with a timed state machine.

---
 rtl/attack_seq_pkg.sv | 30 +++
 rtl/attack_sequencer_phase_timer.sv | 42 ++++
 rtl/attack_sequencer.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/attack_seq_pkg.sv
// Shared definitions for the attack sequencer: state codes, default cycle
// counts and a helper that classifies the armed, motor-driving states.
package attack_seq_pkg;

    localparam int unsigned STATE_W = 3;
    localparam int unsigned SHOT_W  = 8;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE   = 3'd0,
        ST_FIND   = 3'd1,
        ST_PURSUE = 3'd2,
        ST_FIRE   = 3'd3,
        ST_TURN   = 3'd4,
        ST_FAULT  = 3'd5
    } state_e;

    localparam int unsigned DEF_FIND_TIMEOUT   = 200_000_000;
    localparam int unsigned DEF_LOSS_CYCLES    = 5_000_000;
    localparam int unsigned DEF_FIRE_CYCLES    = 10_000_000;
    localparam int unsigned DEF_TURN_CYCLES    = 50_000_000;
    localparam int unsigned DEF_LOCKOUT_CYCLES = 100_000_000;
    localparam int unsigned DEF_CNT_W          = 32;
    localparam int unsigned DEF_MAX_SHOTS      = 3;

    // States in which an overcurrent event forces the lockout.
    function automatic logic is_active(input state_e s);
        return (s == ST_FIND) || (s == ST_PURSUE) || (s == ST_FIRE) || (s == ST_TURN);
    endfunction

endpackage

// File: rtl/attack_sequencer_phase_timer.sv
// phase_timer: shared phase counter for the attack sequencer.
// Ports:
//   clk, rst    - clock, synchronous active-high reset
//   clr         - clear the count to zero (wins over en)
//   en          - count up by one this cycle
//   terminal    - compare value for the current phase
//   done_c      - combinational flag, count equals terminal
module phase_timer #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] terminal,
    output logic             done_c
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: clear has priority over increment.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done_c = (count_q == terminal);

endmodule

// File: rtl/attack_sequencer.sv
// attack_sequencer: timed mode sequencer for the tank drive/turret mux.
// Selects find vs pursue/turn datapath (pr), the turn drive pattern
// (turn_start) and triggers the turret (fire).
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   enable, attack_start     - master enable and arm switches
//   target_lock              - both IR finals asserted
//   border_detect            - firing line reached
//   overcurrent              - H-bridge overcurrent flag
//   pr, turn_start, fire     - registered Moore mode outputs
//   state                    - current state code for LEDs
//   shot_count               - shots since arm, saturating at 255
// Optional build macro SHOT_LIMIT_EN: adds MAX_SHOTS; the FIRE that
// completes with shot_count==MAX_SHOTS returns to IDLE, and re-arming then
// needs attack_start to be released and pressed again.
module attack_sequencer
    import attack_seq_pkg::*;
#(
    parameter int unsigned FIND_TIMEOUT   = DEF_FIND_TIMEOUT,
    parameter int unsigned LOSS_CYCLES    = DEF_LOSS_CYCLES,
    parameter int unsigned FIRE_CYCLES    = DEF_FIRE_CYCLES,
    parameter int unsigned TURN_CYCLES    = DEF_TURN_CYCLES,
    parameter int unsigned LOCKOUT_CYCLES = DEF_LOCKOUT_CYCLES,
    parameter int unsigned CNT_W          = DEF_CNT_W
`ifdef SHOT_LIMIT_EN
    ,
    parameter int unsigned MAX_SHOTS      = DEF_MAX_SHOTS
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       attack_start,
    input  logic       target_lock,
    input  logic       border_detect,
    input  logic       overcurrent,
    output logic       pr,
    output logic       turn_start,
    output logic       fire,
    output logic [2:0] state,
    output logic [7:0] shot_count
);

    localparam logic [CNT_W-1:0] FIND_TC = CNT_W'(FIND_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] LOSS_TC = CNT_W'(LOSS_CYCLES - 1);
    localparam logic [CNT_W-1:0] FIRE_TC = CNT_W'(FIRE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TURN_TC = CNT_W'(TURN_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOCK_TC = CNT_W'(LOCKOUT_CYCLES - 1);
    localparam logic [SHOT_W-1:0] SHOT_SAT = '1;

    state_e            state_q;
    state_e            state_d;
    logic [SHOT_W-1:0] shot_q;
    logic [SHOT_W-1:0] shot_d;
    logic              pr_q;
    logic              pr_d;
    logic              turn_q;
    logic              turn_d;
    logic              fire_q;
    logic              fire_d;

    logic              arm_c;
    logic              tc_c;
    logic              tmr_clr_c;
    logic              tmr_en_c;
    logic [CNT_W-1:0]  terminal_c;

`ifdef SHOT_LIMIT_EN
    logic              limit_hold_q;
    logic              limit_hold_d;
    logic              shot_limit_hit_c;

    assign shot_limit_hit_c = (shot_q == SHOT_W'(MAX_SHOTS));
`endif

    assign arm_c = enable & attack_start;

    // Terminal count for the phase being timed.
    always_comb begin
        terminal_c = '0;
        case (state_q)
            ST_FIND:   terminal_c = FIND_TC;
            ST_PURSUE: terminal_c = LOSS_TC;
            ST_FIRE:   terminal_c = FIRE_TC;
            ST_TURN:   terminal_c = TURN_TC;
            ST_FAULT:  terminal_c = LOCK_TC;
            default:   terminal_c = '0;
        endcase
    end

    // In PURSUE the counter measures the current run of lost-lock cycles.
    assign tmr_clr_c = (state_d != state_q) || ((state_q == ST_PURSUE) && target_lock);
    assign tmr_en_c  = (state_q != ST_IDLE);

    phase_timer #(
        .CNT_W (CNT_W)
    ) u_phase_timer (
        .clk      (clk),
        .rst      (rst),
        .clr      (tmr_clr_c),
        .en       (tmr_en_c),
        .terminal (terminal_c),
        .done_c   (tc_c)
    );

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            shot_q       <= '0;
            pr_q         <= 1'b0;
            turn_q       <= 1'b0;
            fire_q       <= 1'b0;
`ifdef SHOT_LIMIT_EN
            limit_hold_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            shot_q       <= shot_d;
            pr_q         <= pr_d;
            turn_q       <= turn_d;
            fire_q       <= fire_d;
`ifdef SHOT_LIMIT_EN
            limit_hold_q <= limit_hold_d;
`endif
        end
    end

    // Next state: disarm, then overcurrent, then per-state transitions.
    always_comb begin
        state_d = state_q;
        if ((state_q != ST_FAULT) && !arm_c) begin
            state_d = ST_IDLE;
        end else if (overcurrent && is_active(state_q)) begin
            state_d = ST_FAULT;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // Reaching here implies the switches are armed.
`ifdef SHOT_LIMIT_EN
                    if (!limit_hold_q) begin
                        state_d = ST_FIND;
                    end
`else
                    state_d = ST_FIND;
`endif
                end
                ST_FIND: begin
                    if (target_lock) begin
                        state_d = ST_PURSUE;
                    end else if (tc_c) begin
                        state_d = ST_TURN;
                    end
                end
                ST_PURSUE: begin
                    if (border_detect) begin
                        state_d = ST_FIRE;
                    end else if (!target_lock && tc_c) begin
                        state_d = ST_FIND;
                    end
                end
                ST_FIRE: begin
                    if (tc_c) begin
`ifdef SHOT_LIMIT_EN
                        state_d = shot_limit_hit_c ? ST_IDLE : ST_TURN;
`else
                        state_d = ST_TURN;
`endif
                    end
                end
                ST_TURN: begin
                    if (tc_c) begin
                        state_d = ST_FIND;
                    end
                end
                ST_FAULT: begin
                    if (tc_c) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Outputs decoded from the next state so they register alongside it.
    always_comb begin
        pr_d   = 1'b0;
        turn_d = 1'b0;
        fire_d = 1'b0;
        shot_d = shot_q;
        case (state_d)
            ST_PURSUE: pr_d = 1'b1;
            ST_FIRE: begin
                pr_d   = 1'b1;
                fire_d = 1'b1;
            end
            ST_TURN: begin
                pr_d   = 1'b1;
                turn_d = 1'b1;
            end
            default: ;
        endcase
        // Count is zero throughout IDLE; bumps once on FIRE entry.
        if (state_d == ST_IDLE) begin
            shot_d = '0;
        end else if ((state_d == ST_FIRE) && (state_q != ST_FIRE) && (shot_q != SHOT_SAT)) begin
            shot_d = shot_q + SHOT_W'(1);
        end
    end

`ifdef SHOT_LIMIT_EN
    // With the switches still armed, FIRE -> IDLE only happens on the shot limit.
    always_comb begin
        limit_hold_d = limit_hold_q;
        if (!attack_start) begin
            limit_hold_d = 1'b0;
        end else if ((state_q == ST_FIRE) && (state_d == ST_IDLE) && arm_c) begin
            limit_hold_d = 1'b1;
        end
    end
`endif

    assign pr         = pr_q;
    assign turn_start = turn_q;
    assign fire       = fire_q;
    assign state      = state_q;
    assign shot_count = shot_q;

endmodule
